uart_bus_bridge: RTL and testbench

Serial debug bridge that acts as a second initiator on the MCU data-memory bus. It receives 8N1 command frames on its own serial pin and performs one 32-bit write or read per frame on the bus. It returns an acknowledge or the read data on its own serial output. It sits beside the RISC-V core; the top level arbitrates the bus with `bus_req` so the host can load or inspect data memory and memory-mapped peripherals while the core is held.

---
 rtl/uart_bus_bridge_if.sv | 20 ++
 rtl/uart_bus_bridge.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_bridge_if.sv
// Bus-side port bundle of the serial debug bridge: one-cycle request with address, write data and read data.
interface uart_bus_bridge_if #(
    parameter int unsigned WIDTH = 32
);
    logic             bus_req;
    logic [WIDTH-1:0] ram_address;
    logic [WIDTH-1:0] ram_w_data;
    logic             read_write_en;
    logic [WIDTH-1:0] ram_r_data;

    modport master (
        output bus_req, ram_address, ram_w_data, read_write_en,
        input  ram_r_data
    );

    modport slave (
        input  bus_req, ram_address, ram_w_data, read_write_en,
        output ram_r_data
    );
endinterface

// File: rtl/uart_bus_bridge.sv
// 8N1 serial command bridge doing one bus write/read per frame and replying on serial_out.
// Optional inter-byte timeout enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_bus_bridge #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DVSR    = 26,
    parameter int unsigned TIMEOUT = 65536
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              serial_in,
    output logic              serial_out,
    output logic              busy,
    uart_bus_bridge_if.master bus
);
    localparam int unsigned BYTES  = WIDTH / 8;
    localparam int unsigned CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned LEFT_W = $clog2(BYTES + 1);
    localparam int unsigned TICK_W = (DVSR > 1) ? $clog2(DVSR) : 1;

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_REPLY} state_e;

    state_e             state_q, state_d;
    logic               is_write_q, is_write_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   reply_q, reply_d;
    logic [LEFT_W-1:0]  left_q, left_d;
    logic               bus_req_q, rw_q, busy_q;

    logic [TICK_W-1:0]  tick_cnt_q;
    logic               tick_c;

    logic [1:0]         sync_q;
    logic               rx_prev_q, rx_active_q, rx_in_c, rx_valid_c;
    logic [3:0]         rx_tick_q, rx_bit_q;
    logic [7:0]         rx_shift_q;

    logic               tx_busy_q, tx_load_c, tx_end_c, serial_out_q;
    logic [3:0]         tx_tick_q, tx_bit_q;
    logic [7:0]         tx_data_q;
    logic               timeout_c;

    // Free-running oversample tick, shared by receiver and transmitter
    assign tick_c = (tick_cnt_q == TICK_W'(DVSR - 1));
    always_ff @(posedge CLOCK) begin
        if (RESET || tick_c) tick_cnt_q <= '0;
        else                 tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end

    // Receiver: bit 0 is the start bit (checked at tick 7), 1..8 data, 9 stop
    assign rx_in_c    = sync_q[1];
    assign rx_valid_c = rx_active_q && tick_c && (rx_bit_q == 4'd9) && (rx_tick_q == 4'd15) && rx_in_c;
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            rx_active_q <= 1'b0;
            rx_tick_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
        end else begin
            sync_q    <= {sync_q[0], serial_in};
            rx_prev_q <= rx_in_c;
            if (!rx_active_q) begin
                if (rx_prev_q && !rx_in_c) begin
                    rx_active_q <= 1'b1;
                    rx_tick_q   <= '0;
                    rx_bit_q    <= '0;
                end
            end else if (tick_c) begin
                if ((rx_bit_q == 4'd0) && (rx_tick_q == 4'd7)) begin
                    rx_tick_q <= '0;
                    if (rx_in_c) rx_active_q <= 1'b0;
                    else         rx_bit_q    <= 4'd1;
                end else if ((rx_bit_q != 4'd0) && (rx_tick_q == 4'd15)) begin
                    rx_tick_q <= '0;
                    rx_bit_q  <= rx_bit_q + 4'd1;
                    if (rx_bit_q == 4'd9) rx_active_q <= 1'b0;
                    else                  rx_shift_q  <= {rx_in_c, rx_shift_q[7:1]};
                end else begin
                    rx_tick_q <= rx_tick_q + 4'd1;
                end
            end
        end
    end

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            in_frame_c;

    assign in_frame_c = (state_q == S_ADDR) || (state_q == S_DATA);
    assign timeout_c  = in_frame_c && (to_cnt_q == TO_W'(TIMEOUT));
    always_ff @(posedge CLOCK) begin
        if (RESET || !in_frame_c || rx_valid_c) to_cnt_q <= '0;
        else if (!timeout_c)                    to_cnt_q <= to_cnt_q + TO_W'(1);
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Transmitter frame end; back-to-back bytes reload on this same tick
    assign tx_end_c = tx_busy_q && tick_c && (tx_tick_q == 4'd15) && (tx_bit_q == 4'd9);

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        reply_d    = reply_q;
        left_d     = left_q;
        tx_load_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid_c) begin
                    byte_cnt_d = '0;
                    if ((rx_shift_q == OP_WR) || (rx_shift_q == OP_RD)) begin
                        is_write_d = (rx_shift_q == OP_WR);
                        state_d    = S_ADDR;
                    end else begin
                        reply_d = {NAK, (WIDTH - 8)'(0)};
                        left_d  = LEFT_W'(1);
                        state_d = S_REPLY;
                    end
                end
            end
            S_ADDR: begin
                if (timeout_c) begin
                    state_d = S_IDLE;
                end else if (rx_valid_c) begin
                    addr_d     = {addr_q[WIDTH-9:0], rx_shift_q};
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == CNT_W'(BYTES - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = is_write_q ? S_DATA : S_BUS;
                    end
                end
            end
            S_DATA: begin
                if (timeout_c) begin
                    state_d = S_IDLE;
                end else if (rx_valid_c) begin
                    wdata_d    = {wdata_q[WIDTH-9:0], rx_shift_q};
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == CNT_W'(BYTES - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = S_BUS;
                    end
                end
            end
            S_BUS: begin
                state_d = S_REPLY;
                if (is_write_q) begin
                    reply_d = {ACK, (WIDTH - 8)'(0)};
                    left_d  = LEFT_W'(1);
                end else begin
                    reply_d = bus.ram_r_data;
                    left_d  = LEFT_W'(BYTES);
                end
            end
            S_REPLY: begin
                if ((left_q != '0) && tick_c && (!tx_busy_q || tx_end_c)) begin
                    tx_load_c = 1'b1;
                    reply_d   = {reply_q[WIDTH-9:0], 8'h00};
                    left_d    = left_q - LEFT_W'(1);
                end else if ((left_q == '0) && tx_end_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            reply_q    <= '0;
            left_q     <= '0;
            bus_req_q  <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            reply_q    <= reply_d;
            left_q     <= left_d;
            bus_req_q  <= (state_d == S_BUS);
            if (state_d == S_BUS) rw_q <= is_write_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    // Transmit shift register; ones shift in behind the data to form the stop bit
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            tx_busy_q    <= 1'b0;
            tx_tick_q    <= '0;
            tx_bit_q     <= '0;
            tx_data_q    <= 8'hFF;
            serial_out_q <= 1'b1;
        end else if (tx_load_c) begin
            tx_busy_q    <= 1'b1;
            tx_tick_q    <= '0;
            tx_bit_q     <= '0;
            tx_data_q    <= reply_q[WIDTH-1 -: 8];
            serial_out_q <= 1'b0;
        end else if (tx_busy_q && tick_c) begin
            if (tx_tick_q == 4'd15) begin
                tx_tick_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q    <= 1'b0;
                    serial_out_q <= 1'b1;
                end else begin
                    tx_bit_q     <= tx_bit_q + 4'd1;
                    serial_out_q <= tx_data_q[0];
                    tx_data_q    <= {1'b1, tx_data_q[7:1]};
                end
            end else begin
                tx_tick_q <= tx_tick_q + 4'd1;
            end
        end
    end

    assign serial_out        = serial_out_q;
    assign busy              = busy_q;
    assign bus.bus_req       = bus_req_q;
    assign bus.read_write_en = rw_q;
    assign bus.ram_address   = addr_q;
    assign bus.ram_w_data    = wdata_q;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomized scoreboard bench for uart_bus_bridge: a host UART driver, a bus memory, and monitors on bus and serial_out.
module tb_uart_bus_bridge;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned DVSR     = 2;
    localparam int unsigned TIMEOUT  = 1000;
    localparam int unsigned BIT_CLKS = 16 * DVSR;
    localparam int          LIMIT    = 20000;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_exp_t;

    logic clk = 1'b0;
    logic rst, serial_in, serial_out, busy;
    always #5 clk = ~clk;

    uart_bus_bridge_if #(.WIDTH(WIDTH)) bif ();

    uart_bus_bridge #(.WIDTH(WIDTH), .DVSR(DVSR), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK     (clk),
        .RESET     (rst),
        .serial_in (serial_in),
        .serial_out(serial_out),
        .busy      (busy),
        .bus       (bif)
    );

    int errors = 0;
    int checks = 0;
    int rst_gen = 0;
    logic mon_en = 1'b0;

    bus_exp_t    exp_bus[$];
    logic [7:0]  exp_reply[$];
    logic [31:0] ref_mem [16];

    // Bus-side memory: backdoor preset from the stimulus process, otherwise written by the bridge
    logic [31:0] bus_mem [16];
    logic        bd_we;
    logic [3:0]  bd_idx;
    logic [31:0] bd_val;
    always_comb bif.ram_r_data = bus_mem[bif.ram_address[5:2]];
    always @(posedge clk) begin
        if (bd_we) bus_mem[bd_idx] = bd_val;
        else if (bif.bus_req && bif.read_write_en) bus_mem[bif.ram_address[5:2]] = bif.ram_w_data;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic preset(input logic [3:0] idx, input logic [31:0] val);
        bd_idx = idx; bd_val = val; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        serial_in = stop;
        repeat (BIT_CLKS) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d);
        exp_bus.push_back('{we: 1'b1, addr: a, data: d});
        exp_reply.push_back(8'h06);
        ref_mem[a[5:2]] = d;
        send_byte(8'h57, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic issue_read(input logic [31:0] a);
        logic [31:0] v;
        v = ref_mem[a[5:2]];
        exp_bus.push_back('{we: 1'b0, addr: a, data: 32'h0});
        for (int i = 3; i >= 0; i--) exp_reply.push_back(v[8*i +: 8]);
        send_byte(8'h52, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
    endtask

    task automatic issue_unknown(input logic [7:0] b);
        exp_reply.push_back(8'h15);
        send_byte(b, 1'b1);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((exp_reply.size() != 0 || exp_bus.size() != 0 || busy !== 1'b0) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL %s: timed out with replies pending=%0d bus pending=%0d busy=%b, required all drained and busy=0",
                     nm, exp_reply.size(), exp_bus.size(), busy);
        end
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Bus monitor
    bus_exp_t be;
    always @(negedge clk) begin
        if (mon_en && bif.bus_req === 1'b1) begin
            if (exp_bus.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: got bus_req with addr %h rw %b, required none", bif.ram_address, bif.read_write_en);
            end else begin
                be = exp_bus.pop_front();
                chk("bus_rw", 32'(bif.read_write_en), 32'(be.we));
                chk("bus_addr", bif.ram_address, be.addr);
                if (be.we) chk("bus_wdata", bif.ram_w_data, be.data);
            end
        end
    end

    // Serial reply monitor
    initial begin : uart_mon
        logic [7:0] rb;
        logic       sb, pb;
        int         gen;
        wait (mon_en);
        forever begin
            @(negedge serial_out);
            gen = rst_gen;
            repeat (BIT_CLKS / 2) @(negedge clk);
            sb = serial_out;
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CLKS) @(negedge clk);
                rb[i] = serial_out;
            end
            repeat (BIT_CLKS) @(negedge clk);
            pb = serial_out;
            if (gen == rst_gen) begin
                if (exp_reply.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL reply_unexpected: got byte %h, required no reply", rb);
                end else begin
                    chk("reply_byte", 32'(rb), 32'(exp_reply.pop_front()));
                    chk("reply_start", 32'(sb), 32'd0);
                    chk("reply_stop", 32'(pb), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded its time limit, required completion");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] a, d;
        logic [7:0]  ub;
        int          n;
        rst = 1'b1; serial_in = 1'b1; bd_we = 1'b0; bd_idx = '0; bd_val = '0;
        for (int i = 0; i < 16; i++) preset(4'(i), $urandom());
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_serial_out", 32'(serial_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
        chk("rst_rw", 32'(bif.read_write_en), 32'd0);
        chk("rst_addr", bif.ram_address, 32'd0);
        chk("rst_wdata", bif.ram_w_data, 32'd0);
        mon_en = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        issue_write(32'h0000_0100, 32'hDEAD_BEEF);
        wait_done("write_done");
        chk("write_mem", bus_mem[0], 32'hDEAD_BEEF);
        chk("addr_hold", bif.ram_address, 32'h0000_0100);
        chk("wdata_hold", bif.ram_w_data, 32'hDEAD_BEEF);

        preset(4'd0, 32'h1234_5678);
        issue_read(32'h0000_0100);
        wait_done("read_done");

        issue_unknown(8'hA5);
        wait_done("nak_done");
        issue_read(32'h0000_0100);
        wait_done("read_after_nak");

        send_byte(8'h57, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("framing_busy", 32'(busy), 32'd0);
        issue_read(32'h0000_0104);
        wait_done("read_after_framing");

        for (int k = 0; k < 6; k++) begin
            a = $urandom();
            a[1:0] = 2'b00;
            case ($urandom_range(0, 2))
                0: begin d = $urandom(); issue_write(a, d); end
                1: issue_read(a);
                default: begin
                    ub = 8'($urandom());
                    if (ub == 8'h57 || ub == 8'h52) ub = 8'h00;
                    issue_unknown(ub);
                end
            endcase
            wait_done("rand_done");
        end

        // Reset in the middle of a 4-byte reply
        issue_read(32'h0000_0108);
        n = 0;
        while (serial_out !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL reply_start_wait: serial_out stayed %b, required a start bit", serial_out);
        end
        repeat (3 * BIT_CLKS) @(negedge clk);
        rst_gen++;
        rst = 1'b1;
        exp_reply.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_serial_out", 32'(serial_out), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_bus_req", 32'(bif.bus_req), 32'd0);
        repeat (12 * BIT_CLKS) @(negedge clk);
        a = $urandom(); a[1:0] = 2'b00; d = $urandom();
        issue_write(a, d);
        wait_done("write_after_reset");
        issue_read(a);
        wait_done("read_after_reset");

`ifdef UART_BRIDGE_TIMEOUT_EN
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (1200) @(negedge clk);
        chk("timeout_busy", 32'(busy), 32'd0);
        a = $urandom(); a[1:0] = 2'b00; d = $urandom();
        issue_write(a, d);
        wait_done("write_after_timeout");
`endif

        chk("final_bus_queue", 32'(exp_bus.size()), 32'd0);
        chk("final_reply_queue", 32'(exp_reply.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
